// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step clock-enable controller for the 8-bit CPU core.
// Optional pulse counter on ce_count: define CPU_CLK_CTRL_CE_COUNT_EN.
module cpu_clk_ctrl #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cpu_ce,
   output logic             running,
   output logic             step_done,
   output logic [DIV_W-1:0] div_cur,
   output logic [15:0]      ce_count
);

   localparam logic [1:0] ST_HALT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_STEP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             step_q;
   logic             ce_q, ce_d;
   logic             done_q, done_d;
   logic             run_q, run_d;
   logic             step_edge;
   logic [DIV_W-1:0] last_cnt;
   logic             wrap;

   assign step_edge = step_req & ~step_q;
   // A ratio of zero behaves as divide-by-one.
   assign last_cnt  = (div_q == '0) ? '0 : div_q - 1'b1;
   assign wrap      = (cnt_q == last_cnt);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      ce_d    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_HALT: begin
            cnt_d = '0;
            if (cfg_we) div_d = cfg_div;
            if (halt_req)       state_d = ST_HALT;
            else if (step_edge) state_d = ST_STEP;
            else if (run_req)   state_d = ST_RUN;
         end
         ST_RUN: begin
            if (halt_req) begin
               state_d = ST_HALT;
               cnt_d   = '0;
            end else if (wrap) begin
               cnt_d = '0;
               ce_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STEP: begin
            if (halt_req) begin
               state_d = ST_HALT;
               cnt_d   = '0;
            end else if (wrap) begin
               state_d = ST_HALT;
               cnt_d   = '0;
               ce_d    = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_HALT;
            cnt_d   = '0;
         end
      endcase
      run_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HALT;
         cnt_q   <= '0;
         div_q   <= DIV_W'(DEFAULT_DIV);
         step_q  <= 1'b0;
         ce_q    <= 1'b0;
         done_q  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         step_q  <= step_req;
         ce_q    <= ce_d;
         done_q  <= done_d;
         run_q   <= run_d;
      end
   end

`ifdef CPU_CLK_CTRL_CE_COUNT_EN
   logic [15:0] cec_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cec_q <= '0;
      else if (ce_d) cec_q <= cec_q + 16'd1;
   end

   assign ce_count = cec_q;
`else
   assign ce_count = '0;
`endif

   assign cpu_ce    = ce_q;
   assign running   = run_q;
   assign step_done = done_q;
   assign div_cur   = div_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl: reset, run, ratio limits, step,
// priority and pulse counter.
module tb_cpu_clk_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       run_req, halt_req, step_req, cfg_we;
   logic [7:0] cfg_div;
   logic       cpu_ce, running, step_done;
   logic [7:0] div_cur;
   logic [15:0] ce_count;

   int errors = 0;
   int checks = 0;

   cpu_clk_ctrl #(.DIV_W(8), .DEFAULT_DIV(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .run_req   (run_req),
      .halt_req  (halt_req),
      .step_req  (step_req),
      .cfg_we    (cfg_we),
      .cfg_div   (cfg_div),
      .cpu_ce    (cpu_ce),
      .running   (running),
      .step_done (step_done),
      .div_cur   (div_cur),
      .ce_count  (ce_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_div(input logic [7:0] d);
      cfg_div = d;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (cpu_ce !== 1'b0 || running !== 1'b0 || step_done !== 1'b0 ||
          div_cur !== 8'd12 || ce_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_vals: ce=%b run=%b done=%b div=%0d cnt=%0d want 0 0 0 12 0",
                  cpu_ce, running, step_done, div_cur, ce_count);
      end
      set_div(8'd2);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      repeat (4) tick();
      checks++;
      if (cpu_ce !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre: ce=%b want 1", cpu_ce);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (cpu_ce !== 1'b0 || running !== 1'b0 || div_cur !== 8'd12 ||
          step_done !== 1'b0 || ce_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_async: ce=%b run=%b div=%0d done=%b cnt=%0d want 0 0 12 0 0",
                  cpu_ce, running, div_cur, step_done, ce_count);
      end
      #3 rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (cpu_ce !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle c%0d: ce=%b run=%b want 0 0", i, cpu_ce, running);
         end
      end
   endtask

   task automatic test_run_div4();
      set_div(8'd4);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      checks++;
      if (running !== 1'b1 || cpu_ce !== 1'b0) begin
         errors++;
         $display("FAIL run_start: run=%b ce=%b want 1 0", running, cpu_ce);
      end
      for (int i = 1; i <= 12; i++) begin
         if (i == 10) halt_req = 1'b1;
         tick();
         halt_req = 1'b0;
         checks++;
         if (cpu_ce !== (i == 4 || i == 8) || running !== (i < 10)) begin
            errors++;
            $display("FAIL run4 E+%0d: ce=%b run=%b want %b %b",
                     i, cpu_ce, running, (i == 4 || i == 8), (i < 10));
         end
      end
   endtask

   task automatic run_const(input string nm);
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++;
         if (cpu_ce !== 1'b1) begin
            errors++;
            $display("FAIL %s E+%0d: ce=%b want 1", nm, i, cpu_ce);
         end
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++;
      if (cpu_ce !== 1'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL %s_halt: ce=%b run=%b want 0 0", nm, cpu_ce, running);
      end
   endtask

   task automatic test_div_limits();
      cfg_div = 8'd0;
      cfg_we  = 1'b1;
      run_req = 1'b1;
      tick();
      cfg_we  = 1'b0;
      run_req = 1'b0;
      checks++;
      if (div_cur !== 8'd0 || running !== 1'b1) begin
         errors++;
         $display("FAIL div0_cfg: div=%0d run=%b want 0 1", div_cur, running);
      end
      run_const("div0");
      set_div(8'd1);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      run_const("div1");
   endtask

   task automatic test_div255();
      set_div(8'd255);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      for (int i = 1; i <= 520; i++) begin
         tick();
         checks++;
         if (cpu_ce !== (i == 255 || i == 510)) begin
            errors++;
            $display("FAIL div255 E+%0d: ce=%b want %b", i, cpu_ce, (i == 255 || i == 510));
         end
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
   endtask

   task automatic test_step();
      set_div(8'd3);
      step_req = 1'b1;
      tick();
      for (int i = 1; i <= 20; i++) begin
         tick();
         checks++;
         if (cpu_ce !== (i == 3) || step_done !== (i == 3) || running !== 1'b0) begin
            errors++;
            $display("FAIL step S+%0d: ce=%b done=%b run=%b want %b %b 0",
                     i, cpu_ce, step_done, running, (i == 3), (i == 3));
         end
      end
      step_req = 1'b0;
      tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         checks++;
         if (cpu_ce !== (i == 3) || step_done !== (i == 3)) begin
            errors++;
            $display("FAIL step2 S+%0d: ce=%b done=%b want %b", i, cpu_ce, step_done, (i == 3));
         end
      end
   endtask

   task automatic test_priority();
      halt_req = 1'b1;
      run_req  = 1'b1;
      step_req = 1'b1;
      tick();
      halt_req = 1'b0;
      run_req  = 1'b0;
      step_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (cpu_ce !== 1'b0 || running !== 1'b0 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL prio c%0d: ce=%b run=%b done=%b want 0 0 0",
                     i, cpu_ce, running, step_done);
         end
         tick();
      end
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      tick();
      cfg_div = 8'd7;
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
      checks++;
      if (div_cur !== 8'd3 || running !== 1'b1) begin
         errors++;
         $display("FAIL cfg_in_run: div=%0d run=%b want 3 1", div_cur, running);
      end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      for (int i = 2; i <= 8; i++) begin
         tick();
         checks++;
         if (cpu_ce !== 1'b0 || step_done !== 1'b0) begin
            errors++;
            $display("FAIL step_abort S+%0d: ce=%b done=%b want 0 0", i, cpu_ce, step_done);
         end
      end
   endtask

   task automatic test_counter();
      logic [15:0] exp10, exp12;
`ifdef CPU_CLK_CTRL_CE_COUNT_EN
      exp10 = 16'd10;
      exp12 = 16'd12;
`else
      exp10 = 16'd0;
      exp12 = 16'd0;
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_div(8'd2);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      repeat (20) tick();
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++;
      if (ce_count !== exp10) begin
         errors++;
         $display("FAIL cnt_run: got %0d want %0d", ce_count, exp10);
      end
      repeat (2) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         repeat (4) tick();
      end
      checks++;
      if (ce_count !== exp12) begin
         errors++;
         $display("FAIL cnt_step: got %0d want %0d", ce_count, exp12);
      end
   endtask

   initial begin
      rst      = 1'b1;
      run_req  = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
      cfg_we   = 1'b0;
      cfg_div  = 8'd0;
      test_reset();
      test_run_div4();
      test_div_limits();
      test_div255();
      test_step();
      test_priority();
      test_counter();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
